handshake_arbiter: RTL and testbench
====================================

Name: handshake_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one start/ready/done handshake unit among N_REQ requesters.
- Selects one requester, issues a single-cycle start to the shared unit and waits for done.
- Returns a per-requester completion (ack) or timeout (err) pulse.
- Sits between the requester clients and the handshake unit, and owns the unit's start input.

Parameters:
N_REQ, 4, number of requesters (2..16)
TIMEOUT, 255, max cycles in WAIT before abort; 0 disables timeout
CNT_W, $clog2(TIMEOUT+1) (min 1), width of the wait counter (derived, not overridden)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
req  input  N_REQ  per-requester request level; sampled only in IDLE
unit_ready  input  1  shared unit able to accept start
unit_done  input  1  shared unit completion strobe
unit_start  output  1  one-cycle start pulse to shared unit
grant  output  N_REQ  one-hot owner of the shared unit; zero when idle
ack  output  N_REQ  one-cycle completion pulse to the owner
err  output  N_REQ  one-cycle timeout pulse to the owner
busy  output  1  high whenever state != IDLE

Behaviour:
- All outputs are registered.
- Reset (rst=1 at a clock edge) has priority over everything:
  - state=IDLE, rr_ptr=0, counter=0.
  - unit_start, grant, ack, err and busy all 0.
  - Reset mid-transaction aborts it with no ack/err. The shared unit is reset separately.
- States: IDLE, ISSUE, WAIT, DONE, ERR.
- IDLE:
  - If unit_ready=1 and |req, choose winner w = first set req bit scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
  - Next cycle: state=ISSUE, grant=onehot(w), unit_start=1, rr_ptr=(w+1) mod N_REQ.
  - If unit_ready=0 or req=0, stay in IDLE.
- ISSUE:
  - Lasts exactly one cycle; counter cleared; go to WAIT.
  - unit_done is ignored in this state.
- WAIT:
  - unit_start=0. Counter increments each cycle that unit_done=0.
  - unit_done=1 -> DONE.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1 -> ERR.
  - unit_done and timeout in the same cycle: done wins.
- DONE: ack[w]=1 for one cycle, grant still held; next state IDLE with grant=0, ack=0.
- ERR: err[w]=1 for one cycle, grant still held; next state IDLE with grant=0.
- Latency:
  - req/ready sampled in IDLE at edge t -> grant and unit_start visible cycle t+1.
  - unit_done sampled at edge d -> ack visible cycle d+1, IDLE at d+2, earliest next grant d+3.
- Requester rules:
  - A requester drops req after its ack/err or it is re-arbitrated.
  - req deasserted while granted does not cancel the transaction; ack/err still pulses.
- Fairness: with all req bits held, grants rotate 0,1,2,...,N_REQ-1,0. No requester waits more than N_REQ-1 transactions.
- grant, ack and err are always one-hot or zero. ack and err are never high in the same cycle.
- The counter saturates and never wraps. TIMEOUT=0 means WAIT only exits on unit_done.

Test Plan:
- Reset then single request:
  - Stimulus: req=0b0100, unit_ready=1, unit_done at 3rd WAIT cycle.
  - Required: grant=0b0100 and unit_start=1 for exactly one cycle; ack=0b0100 one cycle after done; busy low two cycles after done.
- Round-robin rotation:
  - Stimulus: req=0b1111 held, done returned 2 cycles after each start.
  - Required: grant sequence 0001,0010,0100,1000,0001; no double grants; unit_start count equals ack count.
- Ready gating:
  - Stimulus: req=0b0010, unit_ready=0 for 10 cycles, then 1.
  - Required: grant=0 and unit_start=0 while ready=0; grant=0b0010 one cycle after ready rises.
- Timeout:
  - Stimulus: TIMEOUT=8, req=0b0001, unit_done never asserted.
  - Required: err=0b0001 pulse exactly 9 cycles after the ISSUE cycle; ack stays 0; return to IDLE; next request served normally.
- Done/timeout collision:
  - Stimulus: TIMEOUT=8, unit_done asserted on the cycle counter==7.
  - Required: ack pulses, err stays 0.
- Reset mid-WAIT and req drop:
  - Stimulus: rst=1 during WAIT; then a separate run where req drops during WAIT.
  - Required: after rst, all outputs 0 next cycle, no ack, rr_ptr back to 0 (req=0b1111 grants 0001). In the req-drop run, ack still pulses on done.

Source files
------------

// File: rtl/handshake_arbiter_if.sv
// Requester and shared-unit handshake bundle for handshake_arbiter.
// The arbiter uses the master view; clients and the shared unit use the slave view.
interface handshake_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0] req;
  logic             unit_ready;
  logic             unit_done;
  logic             unit_start;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] ack;
  logic [N_REQ-1:0] err;
  logic             busy;

  modport master (
    input  req, unit_ready, unit_done,
    output unit_start, grant, ack, err, busy
  );

  modport slave (
    output req, unit_ready, unit_done,
    input  unit_start, grant, ack, err, busy
  );
endinterface

// File: rtl/handshake_arbiter.sv
// Round-robin arbiter sharing one start/ready/done handshake unit among N_REQ
// requesters, with per-requester ack/err completion pulses and a wait timeout.
module handshake_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  handshake_arbiter_if.master bus
);

  localparam int unsigned      CNT_W    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned      PTR_W    = (N_REQ < 2) ? 1 : $clog2(N_REQ);
  localparam bit               TO_EN    = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [N_REQ-1:0] ONE      = N_REQ'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] rr_ptr;
  logic [CNT_W-1:0] cnt;

  logic [PTR_W-1:0] win_idx_c;
  logic             win_vld_c;
  int               scan_c;

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    win_idx_c = '0;
    win_vld_c = 1'b0;
    scan_c    = 0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      scan_c = int'(rr_ptr) + i;
      if (scan_c >= int'(N_REQ)) scan_c = scan_c - int'(N_REQ);
      if (bus.req[PTR_W'(scan_c)]) begin
        win_idx_c = PTR_W'(scan_c);
        win_vld_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      rr_ptr         <= '0;
      cnt            <= '0;
      bus.unit_start <= 1'b0;
      bus.grant      <= '0;
      bus.ack        <= '0;
      bus.err        <= '0;
      bus.busy       <= 1'b0;
    end else begin
      bus.unit_start <= 1'b0;
      bus.ack        <= '0;
      bus.err        <= '0;
      case (state)
        S_IDLE: begin
          if (bus.unit_ready && win_vld_c) begin
            state          <= S_ISSUE;
            bus.grant      <= ONE << win_idx_c;
            bus.unit_start <= 1'b1;
            bus.busy       <= 1'b1;
            rr_ptr         <= (int'(win_idx_c) == int'(N_REQ) - 1) ? '0
                                                                   : win_idx_c + PTR_W'(1);
          end
        end
        S_ISSUE: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // Counter saturates so a disabled timeout can wait forever.
          if (!bus.unit_done && cnt != '1) cnt <= cnt + CNT_W'(1);
          if (bus.unit_done) begin
            state   <= S_DONE;
            bus.ack <= bus.grant;
          end else if (TO_EN && cnt == CNT_LAST) begin
            state   <= S_ERR;
            bus.err <= bus.grant;
          end
        end
        S_DONE, S_ERR: begin
          state     <= S_IDLE;
          bus.grant <= '0;
          bus.busy  <= 1'b0;
        end
        default: begin
          state     <= S_IDLE;
          bus.grant <= '0;
          bus.busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_handshake_arbiter.sv
// Vector-table bench for handshake_arbiter: per-cycle stimulus records with
// expected outputs queued in a scoreboard and compared one cycle later.
module tb_handshake_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic rst;

  handshake_arbiter_if #(.N_REQ(N)) bus();

  handshake_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       ready;
    logic       done;
    logic       start;
    logic [3:0] grant;
    logic [3:0] ack;
    logic [3:0] err;
    logic       busy;
  } vec_t;

  typedef struct {
    int         id;
    logic       start;
    logic [3:0] grant;
    logic [3:0] ack;
    logic [3:0] err;
    logic       busy;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  int n_start = 0;
  int n_ack   = 0;
  int n_err   = 0;
  int n_viol  = 0;

  // Protocol monitor: pulse counts and one-hot / exclusivity violations.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.unit_start === 1'b1) n_start++;
      if (bus.ack != 4'b0000) n_ack++;
      if (bus.err != 4'b0000) n_err++;
      if (!$onehot0(bus.grant) || !$onehot0(bus.ack) || !$onehot0(bus.err) ||
          (bus.ack != 4'b0000 && bus.err != 4'b0000))
        n_viol++;
    end
  end

  task automatic add(input logic r, input logic [3:0] rq, input logic rd, input logic dn,
                     input logic st, input logic [3:0] g, input logic [3:0] a,
                     input logic [3:0] e, input logic b);
    vec_t v;
    v.rst = r; v.req = rq; v.ready = rd; v.done = dn;
    v.start = st; v.grant = g; v.ack = a; v.err = e; v.busy = b;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int id, input logic [3:0] act,
                     input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at vec %0d: got %b, want %b", name, id, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic build();
    logic [3:0] g;
    // Reset then single request, done during third WAIT cycle.
    add(1, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
    add(0, 4'b0100, 1, 0, 1, 4'b0100, 4'b0000, 4'b0000, 1);
    for (int k = 0; k < 3; k++)
      add(0, 4'b0100, 1, 0, 0, 4'b0100, 4'b0000, 4'b0000, 1);
    add(0, 4'b0100, 1, 1, 0, 4'b0100, 4'b0100, 4'b0000, 1);
    add(0, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
    add(0, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0);

    // Round-robin with all requests held; first ISSUE also sees a stray done.
    add(1, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
    for (int t = 0; t < 5; t++) begin
      g = 4'b0001 << (t % 4);
      add(0, 4'b1111, 1, 0,        1, g, 4'b0000, 4'b0000, 1);
      add(0, 4'b1111, 1, (t == 0), 0, g, 4'b0000, 4'b0000, 1);
      add(0, 4'b1111, 1, 0,        0, g, 4'b0000, 4'b0000, 1);
      add(0, 4'b1111, 1, 1,        0, g, g,       4'b0000, 1);
      add(0, 4'b1111, 1, 0,        0, 4'b0000, 4'b0000, 4'b0000, 0);
    end

    // Ready gating.
    for (int k = 0; k < 10; k++)
      add(0, 4'b0010, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
    add(0, 4'b0010, 1, 0, 1, 4'b0010, 4'b0000, 4'b0000, 1);
    add(0, 4'b0010, 1, 0, 0, 4'b0010, 4'b0000, 4'b0000, 1);
    add(0, 4'b0010, 1, 1, 0, 4'b0010, 4'b0010, 4'b0000, 1);
    add(0, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0);

    // Timeout: err nine cycles after ISSUE, then a normal transaction.
    add(0, 4'b0001, 1, 0, 1, 4'b0001, 4'b0000, 4'b0000, 1);
    for (int k = 0; k < 8; k++)
      add(0, 4'b0001, 1, 0, 0, 4'b0001, 4'b0000, 4'b0000, 1);
    add(0, 4'b0001, 1, 0, 0, 4'b0001, 4'b0000, 4'b0001, 1);
    add(0, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
    add(0, 4'b0001, 1, 0, 1, 4'b0001, 4'b0000, 4'b0000, 1);
    add(0, 4'b0001, 1, 0, 0, 4'b0001, 4'b0000, 4'b0000, 1);
    add(0, 4'b0001, 1, 1, 0, 4'b0001, 4'b0001, 4'b0000, 1);
    add(0, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0);

    // Done arrives on the last counter value: done wins over timeout.
    add(0, 4'b1000, 1, 0, 1, 4'b1000, 4'b0000, 4'b0000, 1);
    for (int k = 0; k < 8; k++)
      add(0, 4'b1000, 1, 0, 0, 4'b1000, 4'b0000, 4'b0000, 1);
    add(0, 4'b1000, 1, 1, 0, 4'b1000, 4'b1000, 4'b0000, 1);
    add(0, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0);

    // Reset mid-WAIT (with done high), then req drop while granted.
    add(0, 4'b0010, 1, 0, 1, 4'b0010, 4'b0000, 4'b0000, 1);
    add(0, 4'b0010, 1, 0, 0, 4'b0010, 4'b0000, 4'b0000, 1);
    add(0, 4'b0010, 1, 0, 0, 4'b0010, 4'b0000, 4'b0000, 1);
    add(1, 4'b0010, 1, 1, 0, 4'b0000, 4'b0000, 4'b0000, 0);
    add(0, 4'b1111, 1, 0, 1, 4'b0001, 4'b0000, 4'b0000, 1);
    add(0, 4'b0000, 1, 0, 0, 4'b0001, 4'b0000, 4'b0000, 1);
    add(0, 4'b0000, 1, 0, 0, 4'b0001, 4'b0000, 4'b0000, 1);
    add(0, 4'b0000, 1, 1, 0, 4'b0001, 4'b0001, 4'b0000, 1);
    add(0, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
    add(0, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
  endtask

  initial begin
    exp_t e;
    rst            = 1'b1;
    bus.req        = '0;
    bus.unit_ready = 1'b0;
    bus.unit_done  = 1'b0;

    build();

    foreach (vecs[k]) begin
      rst            = vecs[k].rst;
      bus.req        = vecs[k].req;
      bus.unit_ready = vecs[k].ready;
      bus.unit_done  = vecs[k].done;
      sb.push_back('{k, vecs[k].start, vecs[k].grant, vecs[k].ack, vecs[k].err, vecs[k].busy});
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard at vec %0d: got empty queue, want entry", k);
      end else begin
        e = sb.pop_front();
        chk("unit_start", e.id, {3'b000, bus.unit_start}, {3'b000, e.start});
        chk("grant",      e.id, bus.grant,               e.grant);
        chk("ack",        e.id, bus.ack,                 e.ack);
        chk("err",        e.id, bus.err,                 e.err);
        chk("busy",       e.id, {3'b000, bus.busy},      {3'b000, e.busy});
      end
    end

    @(negedge clk);
    chk_int("start_count",   n_start, 12);
    chk_int("ack_count",     n_ack,   10);
    chk_int("err_count",     n_err,   1);
    chk_int("onehot_errors", n_viol,  0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
